// File: rtl/alarm_bank_pkg.sv
// alarm_bank_pkg: shared definitions for the multi-channel alarm unit.
// Holds the BCD digit width, the per-channel state encoding and the
// default ring / snooze lengths used by alarm_bank and alarm_channel.
package alarm_bank_pkg;

   localparam int BCD_BIT_WIDTH  = 4;
   localparam int TIME_W         = 4 * BCD_BIT_WIDTH;  // hh:mm as four BCD digits
   localparam int RING_SEC_DEF   = 60;
   localparam int SNOOZE_MIN_DEF = 5;

   typedef enum logic [1:0] {
      ALM_OFF    = 2'd0,
      ALM_ARMED  = 2'd1,
      ALM_RING   = 2'd2,
      ALM_SNOOZE = 2'd3
   } alm_state_t;

   // Field order matches the packing {hour1, hour0, min1, min0} used on the wires.
   typedef struct packed {
      logic [BCD_BIT_WIDTH-1:0] hour1;
      logic [BCD_BIT_WIDTH-1:0] hour0;
      logic [BCD_BIT_WIDTH-1:0] min1;
      logic [BCD_BIT_WIDTH-1:0] min0;
   } alarm_time_t;

   // Index/counter width that never collapses to zero bits.
   function automatic int width_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/alarm_channel.sv
// alarm_channel: one alarm slot -- stored hh:mm, OFF/ARMED/RINGING/SNOOZE
// state machine, ring-length counter and the BCD match comparator.
// Build option: define ALARM_SNOOZE_EN to enable the snooze state and its
// counter; otherwise the snooze input is ignored and SNOOZE is unreachable.
module alarm_channel
   import alarm_bank_pkg::*;
#(
   parameter int RING_SEC   = RING_SEC_DEF,
   parameter int SNOOZE_MIN = SNOOZE_MIN_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick,
   input  logic              load_hit,
   input  logic              load_arm,
   input  logic [TIME_W-1:0] load_time,
   input  logic [TIME_W-1:0] now_time,
   input  logic              sec_zero,
   input  logic              dismiss,
   input  logic              snooze,
   output logic [TIME_W-1:0] stored_time,
   output logic              armed,
   output logic              ringing,
   output logic              ringing_next
);

   localparam int RING_W = width_min1(RING_SEC);

   alm_state_t        state_q, state_d;
   logic [TIME_W-1:0] time_q, time_d;
   logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
   logic              match;

`ifdef ALARM_SNOOZE_EN
   localparam int SNZ_TICKS = SNOOZE_MIN * 60;
   localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);

   logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
`else
   logic unused_snooze;
   assign unused_snooze = snooze;
   localparam int unused_snooze_min = SNOOZE_MIN;
`endif

   // Illegal BCD is compared verbatim, so it simply never equals a legal time.
   assign match = (now_time == time_q) && sec_zero;

   // Next-state logic: load beats dismiss beats snooze beats tick.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d    = state_q;
      time_d     = time_q;
      ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
      snz_cnt_d  = snz_cnt_q;
`endif
      if (load_hit) begin
         time_d     = load_time;
         state_d    = load_arm ? ALM_ARMED : ALM_OFF;
         ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_d  = '0;
`endif
      end else if (dismiss && (state_q == ALM_RING || state_q == ALM_SNOOZE)) begin
         state_d = ALM_ARMED;
`ifdef ALARM_SNOOZE_EN
      end else if (snooze && state_q == ALM_RING) begin
         state_d   = ALM_SNOOZE;
         snz_cnt_d = SNZ_W'(SNZ_TICKS);
`endif
      end else if (tick) begin
         case (state_q)
            ALM_ARMED: begin
               if (match) begin
                  state_d    = ALM_RING;
                  ring_cnt_d = '0;
               end
            end
            ALM_RING: begin
               if (ring_cnt_q == RING_W'(RING_SEC - 1)) begin
                  state_d    = ALM_ARMED;   // stays armed so the alarm recurs daily
                  ring_cnt_d = '0;
               end else begin
                  ring_cnt_d = ring_cnt_q + RING_W'(1);
               end
            end
`ifdef ALARM_SNOOZE_EN
            ALM_SNOOZE: begin
               if (snz_cnt_q == SNZ_W'(1)) begin
                  state_d    = ALM_RING;
                  ring_cnt_d = '0;
                  snz_cnt_d  = '0;
               end else begin
                  snz_cnt_d = snz_cnt_q - SNZ_W'(1);
               end
            end
`endif
            default: ;
         endcase
      end
   end

   // State, stored time and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ALM_OFF;
         // NOTE: the stored time is a handful of flops, not a RAM, so it is reset to 00:00 like the rest.
         time_q     <= '0;
         ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_q  <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q    <= state_d;
         time_q     <= time_d;
         ring_cnt_q <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
         snz_cnt_q  <= snz_cnt_d;
`endif
      end
   end

   assign stored_time  = time_q;
   assign armed        = (state_q != ALM_OFF);
   assign ringing      = (state_q == ALM_RING);
   assign ringing_next = (state_d == ALM_RING);

endmodule

// File: rtl/alarm_bank.sv
// alarm_bank: N_CH independent BCD hh:mm alarms compared against the running
// time once per second, with readback mux, ring status and a rotating LED ring.
// Build option: define ALARM_SNOOZE_EN to enable snooze (see alarm_channel).
module alarm_bank
   import alarm_bank_pkg::*;
#(
   parameter int N_CH       = 4,
   parameter int CH_W       = width_min1(N_CH),
   parameter int RING_SEC   = RING_SEC_DEF,
   parameter int SNOOZE_MIN = SNOOZE_MIN_DEF,
   parameter int LED_W      = 9
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     tick,
   input  logic [BCD_BIT_WIDTH-1:0] time_sec0,
   input  logic [BCD_BIT_WIDTH-1:0] time_sec1,
   input  logic [BCD_BIT_WIDTH-1:0] time_min0,
   input  logic [BCD_BIT_WIDTH-1:0] time_min1,
   input  logic [BCD_BIT_WIDTH-1:0] time_hour0,
   input  logic [BCD_BIT_WIDTH-1:0] time_hour1,
   input  logic                     load_en,
   input  logic [CH_W-1:0]          load_ch,
   input  logic                     load_arm,
   input  logic [BCD_BIT_WIDTH-1:0] load_min0,
   input  logic [BCD_BIT_WIDTH-1:0] load_min1,
   input  logic [BCD_BIT_WIDTH-1:0] load_hour0,
   input  logic [BCD_BIT_WIDTH-1:0] load_hour1,
   input  logic                     dismiss,
   input  logic                     snooze,
   input  logic [CH_W-1:0]          rd_ch,
   output logic [BCD_BIT_WIDTH-1:0] rd_min0,
   output logic [BCD_BIT_WIDTH-1:0] rd_min1,
   output logic [BCD_BIT_WIDTH-1:0] rd_hour0,
   output logic [BCD_BIT_WIDTH-1:0] rd_hour1,
   output logic [N_CH-1:0]          armed,
   output logic [N_CH-1:0]          ringing,
   output logic                     any_ring,
   output logic [LED_W-1:0]         led
);

   logic [TIME_W-1:0] now_time;
   logic [TIME_W-1:0] load_time;
   logic              sec_zero;
   logic [N_CH-1:0]   load_hit;
   logic [N_CH-1:0]   ringing_next;
   logic [TIME_W-1:0] stored [N_CH];
   alarm_time_t       rd_time;
   logic              any_ring_next;
   logic [LED_W-1:0]  led_q, led_d;

   assign now_time  = {time_hour1, time_hour0, time_min1, time_min0};
   assign load_time = {load_hour1, load_hour0, load_min1, load_min0};
   assign sec_zero  = (time_sec1 == '0) && (time_sec0 == '0);

   // A load_ch beyond N_CH-1 matches no channel and is dropped.
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign load_hit[i] = load_en && (load_ch == CH_W'(i));

      alarm_channel #(
         .RING_SEC   (RING_SEC),
         .SNOOZE_MIN (SNOOZE_MIN)
      ) u_ch (
         .clk          (clk),
         .rst_n        (rst_n),
         .tick         (tick),
         .load_hit     (load_hit[i]),
         .load_arm     (load_arm),
         .load_time    (load_time),
         .now_time     (now_time),
         .sec_zero     (sec_zero),
         .dismiss      (dismiss),
         .snooze       (snooze),
         .stored_time  (stored[i]),
         .armed        (armed[i]),
         .ringing      (ringing[i]),
         .ringing_next (ringing_next[i])
      );
   end

   // Readback mux; an out-of-range rd_ch reads all zeros.
   always_comb begin
      rd_time = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (rd_ch == CH_W'(i)) rd_time = stored[i];
      end
   end

   assign rd_min0  = rd_time.min0;
   assign rd_min1  = rd_time.min1;
   assign rd_hour0 = rd_time.hour0;
   assign rd_hour1 = rd_time.hour1;

   assign any_ring      = |ringing;
   assign any_ring_next = |ringing_next;

   // LED rotator: keyed off next-cycle ringing so led moves in step with ringing.
   always_comb begin
      led_d = '0;
      if (any_ring_next) begin
         if (!any_ring)  led_d = LED_W'(1);
         else if (tick)  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
         else            led_d = led_q;
      end
   end

   // LED pattern register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_q <= '0;
      else        led_q <= led_d;
   end

   assign led = led_q;

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-channel alarm unit that replaces the single-alarm block in the clock top level. It holds `N_CH` independent BCD hh:mm alarms and compares each against the running time-of-day once per second. It drives per-channel ring/arm status plus a rotating LED pattern, and supports dismiss and an optional snooze. It sits beside the time-display counter and is loaded from the setting registers under FSM control.

## Interface
- `N_CH`, 4: number of alarm channels (1..16).
- `CH_W`, `$clog2(N_CH)` (min 1): channel index width.
- `RING_SEC`, 60: ticks a channel rings before auto-stop (≥1).
- `SNOOZE_MIN`, 5: snooze length in minutes (≥1).
- `LED_W`, 9: width of the LED ring pattern (≥2).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `tick` in 1: 1 Hz enable, one `clk` cycle wide.
- `time_sec0`, `time_sec1`, `time_min0`, `time_min1`, `time_hour0`, `time_hour1` in `BCD_BIT_WIDTH` each: current time.
- `load_en` in 1: write alarm channel `load_ch`.
- `load_ch` in `CH_W`: target channel.
- `load_arm` in 1: 1 = arm on load, 0 = disarm.
- `load_min0`, `load_min1`, `load_hour0`, `load_hour1` in `BCD_BIT_WIDTH` each: alarm time to store.
- `dismiss` in 1: one-cycle pulse, stops all ringing/snoozing channels.
- `snooze` in 1: one-cycle pulse, snoozes all ringing channels.
- `rd_ch` in `CH_W`: readback channel select.
- `rd_min0`, `rd_min1`, `rd_hour0`, `rd_hour1` out `BCD_BIT_WIDTH` each: stored time of `rd_ch`; combinational.
- `armed` out `N_CH`: channel state ≠ OFF.
- `ringing` out `N_CH`: channel state = RINGING.
- `any_ring` out 1: OR of `ringing`.
- `led` out `LED_W`: ring pattern.

## Operation
- Per-channel FSM states: OFF, ARMED, RINGING, SNOOZE.
- Transitions on a cycle, evaluated in priority order (first match wins):
  1. `load_en` with `load_ch` equal to this channel: store the time. `load_arm`=1 goes to ARMED; 0 goes to OFF. Both clear the ring and snooze counters. Applies from any state.
  2. `dismiss`: RINGING or SNOOZE goes to ARMED.
  3. `snooze`: RINGING goes to SNOOZE, snooze counter = `SNOOZE_MIN*60`.
  4. `tick`:
     - ARMED goes to RINGING when hh:mm equals the stored time and `time_sec1:time_sec0`=00. Ring counter cleared.
     - RINGING increments the ring counter. At `RING_SEC-1` it goes to ARMED.
     - SNOOZE decrements the snooze counter. At 1 it goes to RINGING with the ring counter cleared.
- Compare is 4-digit BCD equality. There is no range check: illegal BCD is stored verbatim and never matches a legal time.
- `load_ch` ≥ `N_CH`: load ignored. `rd_ch` ≥ `N_CH`: readback is all zeros.
- ARMED stays armed after ringing, so the alarm recurs daily.
- LED pattern:
  - When `any_ring` goes 0→1 (registered), `led` = 1 in the LSB.
  - While `any_ring`=1, `led` rotates left one position per `tick`.
  - When `any_ring`=0, `led` = 0.
- Channels are fully independent. Several may ring at once; one `dismiss` or `snooze` acts on all of them.

## Timing
- Reset values:
  - All channels OFF.
  - Stored times 00:00.
  - Counters 0.
  - `armed`, `ringing`, `any_ring`, `led` = 0.
- `ringing` rises one cycle after the matching `tick` cycle. `any_ring` follows combinationally from registered `ringing`.
- `dismiss`/`snooze` take effect on the next edge, so `ringing` drops one cycle after the pulse.
- A load is visible on the rd_* outputs and `armed` one cycle after `load_en`.
- Ringing lasts exactly `RING_SEC` ticks. Snooze lasts exactly `SNOOZE_MIN*60` ticks.
- A `dismiss` and a matching `tick` in the same cycle: the channel rings (dismiss does not affect ARMED).
- A `load_en` on the matching `tick` cycle: load wins and there is no ring that cycle.
- Reset asserted mid-ring: immediate return to reset values.

## Configuration
- `ALARM_SNOOZE_EN` defined: SNOOZE state, snooze counter and the `snooze` input are active as above.
- Not defined:
  - `snooze` is ignored and the SNOOZE state is unreachable.
  - No snooze counter is synthesised.
  - `SNOOZE_MIN` is unused.
  - Port list unchanged.

## Structure
- The shared header (`global.v`) gains:
  - state encodings `ALM_OFF`, `ALM_ARMED`, `ALM_RING`, `ALM_SNOOZE`;
  - the default `RING_SEC` and `SNOOZE_MIN`.
- `BCD_BIT_WIDTH` is taken from the same header.
- Sub-module `alarm_channel`: one channel's stored time, FSM, ring and snooze counters, and match comparator. Instantiated `N_CH` times with a generate loop.
- The top of `alarm_bank` holds the readback mux, the `any_ring` reduction and the LED rotator.

## Test plan
Bench parameters: `N_CH`=4, `RING_SEC`=5, `SNOOZE_MIN`=1.
- Load ch2 with 07:30, arm=1. Drive time 07:29:59 → 07:30:00 with `tick` → `ringing`=4'b0100 one cycle later. It auto-clears after 5 ticks and `armed[2]` stays 1.
- Ch0 and ch3 both set to 12:00, reached at 12:00:00 → `ringing`=4'b1001. One `dismiss` pulse → `ringing`=0 next cycle and `led`=0.
- With `ALARM_SNOOZE_EN`: ch1 ringing, pulse `snooze` → `ringing`=0. After 60 ticks `ringing[1]`=1 again. Without the macro, `snooze` has no effect.
- `led` while ringing: 1 → 2 → 4 … per tick, wrapping from bit 8 to bit 0 after 9 ticks.
- Load ch1 with arm=0 while it is ringing → `ringing[1]`=0 and `armed[1]`=0. `rd_ch`=1 reads back the new time.
- Assert `rst_n`=0 mid-ring → all outputs 0 and `rd_*`=00:00 immediately.
